// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: state encodings,
// busy-bit indices, IO space base and the accepted transfer lengths.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_MREAD  = 3'd1,
    MC_MWRITE = 3'd2,
    MC_IFETCH = 3'd3,
    MC_DONE   = 3'd4
  } mc_state_e;

  localparam int BUSY_ACTIVE_BIT = 1;
  localparam int BUSY_FETCH_BIT  = 0;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  function automatic logic len_valid(input logic [2:0] len);
    return (len == LEN_BYTE) || (len == LEN_HALF) || (len == LEN_WORD);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the memory-stage, fetch and byte-wide RAM/IO bus signals.
// slave = controller side, master = requesters plus RAM model.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              read_mem;
  logic              write_mem;
  logic [ADDR_W-1:0] mem_addr_to_read;
  logic [31:0]       mem_data_to_write;
  logic [2:0]        data_len;
  logic              mem_load_done;
  logic [31:0]       mem_ctrl_read_in;
  logic [1:0]        mem_ctrl_busy_state;

  logic              if_read;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_inst;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  read_mem, write_mem, mem_addr_to_read, mem_data_to_write, data_len,
    input  if_read, if_addr, if_flush, ram_din,
    output mem_load_done, mem_ctrl_read_in, mem_ctrl_busy_state,
    output if_done, if_inst, ram_dout, ram_a, ram_wr
  );

  modport master (
    output read_mem, write_mem, mem_addr_to_read, mem_data_to_write, data_len,
    output if_read, if_addr, if_flush, ram_din,
    input  mem_load_done, mem_ctrl_read_in, mem_ctrl_busy_state,
    input  if_done, if_inst, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_ctrl_byte_asm.sv
// Counter-indexed 32-bit byte buffer: captures read bytes into a word and
// selects the outgoing byte of a store word.
module mem_ctrl_byte_asm (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_en,
  input  logic [31:0] load_val,
  input  logic        cap_en,
  input  logic [1:0]  cap_idx,
  input  logic [7:0]  cap_byte,
  input  logic [1:0]  sel_idx,
  output logic [31:0] word,
  output logic [7:0]  sel_byte
);

  logic [31:0] asm_q, asm_d;

  // word includes the byte being captured this cycle, so the final byte
  // and the completion can be registered on the same edge
  always_comb begin
    word = asm_q;
    if (cap_en) word[{cap_idx, 3'b000} +: 8] = cap_byte;
    asm_d = load_en ? load_val : word;
  end

  assign sel_byte = asm_q[{sel_idx, 3'b000} +: 8];

  always_ff @(posedge clk_in) begin
    if (!rst_in) asm_q <= '0;
    else         asm_q <= asm_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and load/store requests onto a byte-wide
// RAM/IO bus. Define MEMCTRL_IO_FULL_EN to stall IO-space writes on io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEMCTRL_IO_FULL_EN
  ,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
`endif
) (
  input  logic      clk_in,
  input  logic      rst_in,
`ifdef MEMCTRL_IO_FULL_EN
  input  logic      io_buffer_full,
`endif
  mem_ctrl_if.slave bus
);

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              fetch_q, fetch_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [1:0]        busy_q, busy_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic              asm_load, cap_en;
  logic [31:0]       asm_val, asm_word;
  logic [7:0]        asm_byte;
  logic [ADDR_W-1:0] cur_addr;
  logic              stall;

  assign cur_addr = base_q + ADDR_W'(cnt_q);

`ifdef MEMCTRL_IO_FULL_EN
  assign stall = (cur_addr >= IO_BASE) && io_buffer_full;
`else
  assign stall = 1'b0;
`endif

  mem_ctrl_byte_asm u_byte_asm (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_en  (asm_load),
    .load_val (asm_val),
    .cap_en   (cap_en),
    .cap_idx  (cnt_q[1:0] - 2'd2),
    .cap_byte (bus.ram_din),
    .sel_idx  (cnt_q[1:0]),
    .word     (asm_word),
    .sel_byte (asm_byte)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    fetch_d    = fetch_q;
    mem_done_d = 1'b0;
    rd_data_d  = '0;
    if_done_d  = 1'b0;
    if_inst_d  = '0;
    ram_a_d    = '0;
    ram_dout_d = '0;
    ram_wr_d   = 1'b0;
    asm_load   = 1'b0;
    asm_val    = '0;
    cap_en     = 1'b0;

    case (state_q)
      MC_IDLE: begin
        if (bus.write_mem && len_valid(bus.data_len)) begin
          state_d  = MC_MWRITE;
          base_d   = bus.mem_addr_to_read;
          len_d    = bus.data_len;
          cnt_d    = '0;
          fetch_d  = 1'b0;
          asm_load = 1'b1;
          asm_val  = bus.mem_data_to_write;
        end else if (bus.read_mem && len_valid(bus.data_len)) begin
          state_d  = MC_MREAD;
          base_d   = bus.mem_addr_to_read;
          len_d    = bus.data_len;
          cnt_d    = '0;
          fetch_d  = 1'b0;
          asm_load = 1'b1;
        end else if (bus.if_read && !bus.if_flush) begin
          state_d  = MC_IFETCH;
          base_d   = bus.if_addr;
          len_d    = LEN_WORD;
          cnt_d    = '0;
          fetch_d  = 1'b1;
          asm_load = 1'b1;
        end
      end

      // Address goes out on counts 0..N-1; its byte is sampled two counts later
      MC_MREAD, MC_IFETCH: begin
        if (state_q == MC_IFETCH && bus.if_flush) begin
          state_d = MC_IDLE;
          fetch_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          cap_en = (cnt_q >= 3'd2);
          if (cnt_q < len_q) ram_a_d = cur_addr;
          if (cnt_q == len_q + 3'd1) begin
            state_d = MC_DONE;
            if (fetch_q) begin
              if_done_d = 1'b1;
              if_inst_d = asm_word;
            end else begin
              mem_done_d = 1'b1;
              rd_data_d  = asm_word;
            end
          end
        end
      end

      MC_MWRITE: begin
        if (cnt_q == len_q) begin
          state_d    = MC_DONE;
          mem_done_d = 1'b1;
        end else if (!stall) begin
          ram_a_d    = cur_addr;
          ram_dout_d = asm_byte;
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          ram_a_d = cur_addr;
        end
      end

      MC_DONE: begin
        state_d = MC_IDLE;
        fetch_d = 1'b0;
      end

      default: begin
        state_d = MC_IDLE;
        fetch_d = 1'b0;
      end
    endcase

    busy_d                  = '0;
    busy_d[BUSY_ACTIVE_BIT] = (state_d != MC_IDLE);
    busy_d[BUSY_FETCH_BIT]  = (state_d == MC_IFETCH) || (state_d == MC_DONE && fetch_d);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= MC_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      fetch_q    <= 1'b0;
      mem_done_q <= 1'b0;
      rd_data_q  <= '0;
      if_done_q  <= 1'b0;
      if_inst_q  <= '0;
      busy_q     <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      fetch_q    <= fetch_d;
      mem_done_q <= mem_done_d;
      rd_data_q  <= rd_data_d;
      if_done_q  <= if_done_d;
      if_inst_q  <= if_inst_d;
      busy_q     <= busy_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  assign bus.mem_load_done       = mem_done_q;
  assign bus.mem_ctrl_read_in    = rd_data_q;
  assign bus.mem_ctrl_busy_state = busy_q;
  assign bus.if_done             = if_done_q;
  assign bus.if_inst             = if_inst_q;
  assign bus.ram_a               = ram_a_q;
  assign bus.ram_dout            = ram_dout_q;
  assign bus.ram_wr              = ram_wr_q;

endmodule
